// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core widths, flag indices and write-source encodings
package cpu_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_SEL_W = 3;

    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic W_SRC_ALU = 1'b0;
    localparam logic W_SRC_ID  = 1'b1;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one register-file read port: select decode, bypass compare, output mux
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32
) (
    input  logic [REG_SEL_W-1:0] i_sel,
    input  logic [DATA_W-1:0]    i_regs [NUM_REGS],
    input  logic                 i_w_enable,
    input  logic [REG_SEL_W-1:0] i_w_reg,
    input  logic [DATA_W-1:0]    i_w_data,
    output logic [DATA_W-1:0]    o_val
);

    logic w_sel_ok;
    logic w_hit;

    // Out-of-range selects read as zero and never match a (dropped) write.
    assign w_sel_ok = (32'(i_sel) < NUM_REGS);
    assign w_hit    = i_w_enable && (i_w_reg == i_sel) && w_sel_ok;

    always_comb begin
        o_val = '0;
        if (w_hit) begin
            o_val = i_w_data;
        end else if (w_sel_ok) begin
            o_val = i_regs[i_sel];
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - architectural register file and CPSR with write merge and write-through bypass
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_SEL_W-1:0] r_sel_0,
    input  logic [REG_SEL_W-1:0] r_sel_1,
    input  logic [REG_SEL_W-1:0] r_sel_p,
    output logic [DATA_W-1:0]    r_val_0,
    output logic [DATA_W-1:0]    r_val_1,
    output logic [DATA_W-1:0]    r_val_p,
    input  logic                 w_enable,
    input  logic                 w_select,
    input  logic [REG_SEL_W-1:0] w_reg,
    input  logic [DATA_W-1:0]    w_alu,
    input  logic [DATA_W-1:0]    w_id,
    input  logic                 w_hi_only,
    input  logic [3:0]           flags_in,
    input  logic                 flags_we,
    output logic [3:0]           cpsr
);

    localparam int HALF = DATA_W / 2;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [3:0]        r_cpsr;

    logic              w_wreg_ok;
    logic [DATA_W-1:0] w_wd;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    assign w_wreg_ok = (32'(w_reg) < NUM_REGS);
    assign w_wd      = (w_select == W_SRC_ID) ? w_id : w_alu;

    always_comb begin
        w_old = '0;
        if (w_wreg_ok) begin
            w_old = r_regs[w_reg];
        end
    end

    // MOVT keeps the destination's current low half.
    assign w_merged = w_hi_only ? {w_wd[DATA_W-1:HALF], w_old[HALF-1:0]} : w_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_enable && w_wreg_ok) begin
            r_regs[w_reg] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpsr <= 4'b0000;
        end else if (flags_we) begin
            r_cpsr <= flags_in;
        end
    end

    assign cpsr = r_cpsr;

    rf_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_port_0 (
        .i_sel      (r_sel_0),
        .i_regs     (r_regs),
        .i_w_enable (w_enable),
        .i_w_reg    (w_reg),
        .i_w_data   (w_merged),
        .o_val      (r_val_0)
    );

    rf_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_port_1 (
        .i_sel      (r_sel_1),
        .i_regs     (r_regs),
        .i_w_enable (w_enable),
        .i_w_reg    (w_reg),
        .i_w_data   (w_merged),
        .o_val      (r_val_1)
    );

    rf_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_port_p (
        .i_sel      (r_sel_p),
        .i_regs     (r_regs),
        .i_w_enable (w_enable),
        .i_w_reg    (w_reg),
        .i_w_data   (w_merged),
        .o_val      (r_val_p)
    );

endmodule
